// File: rtl/bf_1_a_reg.sv
// Registered 3-input truth-table evaluator with valid strobe and ones counter.
// Define BF_1_A_INPUT_SYNC_EN to add 2-flop input synchronizers.
module bf_1_a_reg #(
  parameter logic [7:0] TRUTH_TABLE = 8'h3A,
  parameter int         COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inA,
  input  logic               inB,
  input  logic               inC,
  input  logic               in_valid,
  output logic               out,
  output logic               out_valid,
  output logic [2:0]         minterm,
  output logic [COUNT_W-1:0] ones_count
);

  logic [3:0] raw;
  logic [3:0] smp;

  assign raw = {inA, inB, inC, in_valid};

`ifdef BF_1_A_INPUT_SYNC_EN
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign smp = sync2_q;
`else
  assign smp = raw;
`endif

  logic [2:0]         idx;
  logic               vld;
  logic               f;
  logic               out_q, out_d;
  logic               vld_q, vld_d;
  logic [2:0]         mt_q, mt_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  assign idx = smp[3:1];
  assign vld = smp[0];
  assign f   = TRUTH_TABLE[idx];

  always_comb begin
    out_d = f;
    vld_d = vld;
    mt_d  = idx;
    cnt_d = cnt_q;
    // Saturate at all-ones instead of wrapping
    if (vld && f && (cnt_q != {COUNT_W{1'b1}}))
      cnt_d = cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 1'b0;
      vld_q <= 1'b0;
      mt_q  <= 3'b000;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
      mt_q  <= mt_d;
      cnt_q <= cnt_d;
    end
  end

  assign out        = out_q;
  assign out_valid  = vld_q;
  assign minterm    = mt_q;
  assign ones_count = cnt_q;

endmodule

// File: tb/tb_bf_1_a_reg.sv
// Bench for bf_1_a_reg: three instances (default, 3-bit counter, 8'h80 table)
// checked against a latency-queue model of the boolean functions.
module tb_bf_1_a_reg;

`ifdef BF_1_A_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk, rst;
  logic inA, inB, inC, in_valid;

  logic       o0, o1, o2;
  logic       v0, v1, v2;
  logic [2:0] m0, m1, m2;
  logic [7:0] c0;
  logic [2:0] c1;
  logic [7:0] c2;

  int checks = 0;
  int failures = 0;

  bf_1_a_reg #(.TRUTH_TABLE(8'h3A), .COUNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
    .in_valid(in_valid), .out(o0), .out_valid(v0),
    .minterm(m0), .ones_count(c0)
  );

  bf_1_a_reg #(.TRUTH_TABLE(8'h3A), .COUNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
    .in_valid(in_valid), .out(o1), .out_valid(v1),
    .minterm(m1), .ones_count(c1)
  );

  bf_1_a_reg #(.TRUTH_TABLE(8'h80), .COUNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
    .in_valid(in_valid), .out(o2), .out_valid(v2),
    .minterm(m2), .ones_count(c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [3:0] pend[$];
  logic       mo[3];
  logic       mv;
  logic [2:0] mm;
  int         mc[3];
  int         cmax[3] = '{255, 7, 255};

  function automatic logic fm(input int i, input logic [2:0] x);
    logic a, b, c;
    {a, b, c} = x;
    if (i == 2) return a & b & c;
    return (!a & c) | (a & !b);
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int k = 0; k < LAT - 1; k++) pend.push_back(4'h0);
    mv = 1'b0;
    mm = 3'b000;
    for (int i = 0; i < 3; i++) begin
      mo[i] = 1'b0;
      mc[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [2:0] x, input logic v);
    logic [3:0] s;
    pend.push_back({x, v});
    s = pend.pop_front();
    mm = s[3:1];
    mv = s[0];
    for (int i = 0; i < 3; i++) begin
      mo[i] = fm(i, mm);
      if (mv && mo[i] && mc[i] < cmax[i]) mc[i]++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, " out0"}, {7'd0, o0}, {7'd0, mo[0]});
    chk({ph, " out1"}, {7'd0, o1}, {7'd0, mo[1]});
    chk({ph, " out2"}, {7'd0, o2}, {7'd0, mo[2]});
    chk({ph, " vld0"}, {7'd0, v0}, {7'd0, mv});
    chk({ph, " vld1"}, {7'd0, v1}, {7'd0, mv});
    chk({ph, " vld2"}, {7'd0, v2}, {7'd0, mv});
    chk({ph, " mt0"}, {5'd0, m0}, {5'd0, mm});
    chk({ph, " mt1"}, {5'd0, m1}, {5'd0, mm});
    chk({ph, " mt2"}, {5'd0, m2}, {5'd0, mm});
    chk({ph, " cnt0"}, c0, mc[0][7:0]);
    chk({ph, " cnt1"}, {5'd0, c1}, mc[1][7:0]);
    chk({ph, " cnt2"}, c2, mc[2][7:0]);
  endtask

  task automatic step(input string ph, input logic [2:0] x,
                      input logic v);
    {inA, inB, inC} = x;
    in_valid = v;
    @(posedge clk);
    model_edge(x, v);
    #1;
    check_all(ph);
  endtask

  // Called 1 unit after an edge: asserts rst mid-cycle and releases before
  // the next edge, checking the asynchronous clear.
  task automatic async_reset(input string ph);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(ph);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {inA, inB, inC} = 3'b101;
    in_valid = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset");
    #3;
    rst = 1'b0;

    repeat (LAT) step("post_reset", 3'b101, 1'b1);

    for (int i = 0; i < 8; i++) step("sweep", 3'(i), 1'b1);
    repeat (LAT) step("flush", 3'b000, 1'b0);

    repeat (5) step("gating", 3'b011, 1'b0);

    repeat (10) step("sat100", 3'b100, 1'b1);
    repeat (10) step("sat111", 3'b111, 1'b1);

    for (int i = 0; i < 8; i++) begin
      step("sweep2", 3'(i), 1'b1);
      if (i == 3) async_reset("midreset");
    end
    repeat (LAT) step("flush2", 3'b000, 1'b0);

    for (int n = 0; n < 400; n++) begin
      step("rand", 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
